// File: rtl/rotary_menu_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rotary_menu_controller                                        |
// | Purpose  : Three-field menu editor driven by decoded rotary detents and  |
// |            a debounced push button (browse / edit / commit).             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rotary_menu_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACCEL_WINDOW    = 2500000,
    parameter int FAST_STEP       = 4,
    parameter int MAX_VALUE       = 255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       rotary_event,
    input  logic       rotary_right,
    input  logic       BTN,
    output logic [1:0] field_sel,
    output logic       edit_mode,
    output logic [7:0] edit_value,
    output logic [7:0] value0,
    output logic [7:0] value1,
    output logic [7:0] value2,
    output logic       update_strobe
);

    localparam int             DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int             GAP_W    = $clog2(ACCEL_WINDOW + 1);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(ACCEL_WINDOW);
    localparam logic [7:0]     STEP_FAST = 8'(FAST_STEP);
    localparam logic [7:0]     MAX8      = 8'(MAX_VALUE);

    typedef enum logic [1:0] {
        ST_BROWSE = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button path: synchronizer, stability counter, rising-edge press
    // ------------------------------------------------------------------
    logic            btn_meta_q, btn_sync_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_level_q, db_level_d;
    logic            press;

    // The press pulse fires on the same edge the debounced level rises,
    // so the FSM reacts without an extra cycle of delay.
    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        press      = 1'b0;
        if (btn_sync_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_level_d = btn_sync_q;
            db_cnt_d   = '0;
            press      = btn_sync_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Synchronizer and debounce state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            btn_meta_q <= BTN;
            btn_sync_q <= btn_meta_q;
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
        end
    end

    // ------------------------------------------------------------------
    // Menu FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [1:0]       field_sel_q, field_sel_d;
    logic [7:0]       edit_value_q, edit_value_d;
    logic [2:0][7:0]  value_q, value_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             edit_mode_q, edit_mode_d;
    logic             update_strobe_q, update_strobe_d;
    logic [7:0]       cur_value;
    logic [7:0]       step;
    logic [8:0]       sum9;

    // Next-state logic: field selection, saturating edit arithmetic, commit
    always_comb begin
        state_d         = state_q;
        field_sel_d     = field_sel_q;
        edit_value_d    = edit_value_q;
        value_d         = value_q;
        gap_d           = gap_q;
        update_strobe_d = 1'b0;

        case (field_sel_q)
            2'd0:    cur_value = value_q[0];
            2'd1:    cur_value = value_q[1];
            2'd2:    cur_value = value_q[2];
            default: cur_value = 8'd0;
        endcase

        // A gap counter below the window means the previous edit detent was recent
        step = (gap_q < GAP_SAT) ? STEP_FAST : 8'd1;
        sum9 = {1'b0, edit_value_q} + {1'b0, step};

        case (state_q)
            ST_BROWSE: begin
                if (press) begin
                    state_d      = ST_EDIT;
                    edit_value_d = cur_value;
                    gap_d        = GAP_SAT;
                end else if (rotary_event) begin
                    if (rotary_right) begin
                        field_sel_d = (field_sel_q == 2'd2) ? 2'd0 : field_sel_q + 2'd1;
                    end else begin
                        field_sel_d = (field_sel_q == 2'd0) ? 2'd2 : field_sel_q - 2'd1;
                    end
                end
            end
            ST_EDIT: begin
                if (press) begin
                    state_d         = ST_COMMIT;
                    update_strobe_d = 1'b1;
                    case (field_sel_q)
                        2'd0:    value_d[0] = edit_value_q;
                        2'd1:    value_d[1] = edit_value_q;
                        2'd2:    value_d[2] = edit_value_q;
                        default: value_d    = value_q;
                    endcase
                end else if (rotary_event) begin
                    gap_d = '0;
                    if (rotary_right) begin
                        edit_value_d = (sum9 > {1'b0, MAX8}) ? MAX8 : sum9[7:0];
                    end else begin
                        edit_value_d = (edit_value_q < step) ? 8'd0 : edit_value_q - step;
                    end
                end else if (gap_q != GAP_SAT) begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_BROWSE;
            end
            default: begin
                state_d = ST_BROWSE;
            end
        endcase

        // Encoding 3 is never produced; recover from it should it appear
        if (field_sel_q == 2'd3) begin
            field_sel_d = 2'd0;
        end

        edit_mode_d = (state_d == ST_EDIT);
    end

    // FSM and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= ST_BROWSE;
            field_sel_q     <= 2'd0;
            edit_value_q    <= 8'd0;
            value_q         <= '0;
            gap_q           <= GAP_SAT;
            edit_mode_q     <= 1'b0;
            update_strobe_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            field_sel_q     <= field_sel_d;
            edit_value_q    <= edit_value_d;
            value_q         <= value_d;
            gap_q           <= gap_d;
            edit_mode_q     <= edit_mode_d;
            update_strobe_q <= update_strobe_d;
        end
    end

    assign field_sel     = field_sel_q;
    assign edit_mode     = edit_mode_q;
    assign edit_value    = edit_value_q;
    assign value0        = value_q[0];
    assign value1        = value_q[1];
    assign value2        = value_q[2];
    assign update_strobe = update_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_rotary_menu_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rotary_menu_controller                                     |
// | Purpose  : Self-checking bench with a behavioural menu model, scripted   |
// |            scenarios and a randomized phase.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_rotary_menu_controller;

    localparam int DEB  = 4;
    localparam int AW   = 16;
    localparam int FS   = 4;
    localparam int MAXV = 255;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       rotary_event = 1'b0;
    logic       rotary_right = 1'b0;
    logic       BTN = 1'b0;
    logic [1:0] field_sel;
    logic       edit_mode;
    logic [7:0] edit_value;
    logic [7:0] value0, value1, value2;
    logic       update_strobe;

    int n_cmp = 0;
    int n_bad = 0;

    rotary_menu_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .ACCEL_WINDOW   (AW),
        .FAST_STEP      (FS),
        .MAX_VALUE      (MAXV)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .rotary_event (rotary_event),
        .rotary_right (rotary_right),
        .BTN          (BTN),
        .field_sel    (field_sel),
        .edit_mode    (edit_mode),
        .edit_value   (edit_value),
        .value0       (value0),
        .value1       (value1),
        .value2       (value2),
        .update_strobe(update_strobe)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Behavioural model: button history as a run length of disagreeing
    // samples, menu as a mode number plus plain integer arithmetic.
    // ------------------------------------------------------------------
    int m_s1, m_s2, m_deb, m_run, m_press;
    int m_mode;      // 0 browse, 1 edit, 2 commit
    int m_fsel, m_ev, m_gap, m_step, m_strobe;
    int m_val [3];

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0;
        m_mode = 0; m_fsel = 0; m_ev = 0; m_gap = AW; m_strobe = 0;
        for (int i = 0; i < 3; i++) m_val[i] = 0;
    endtask

    task automatic model_step();
        m_press = 0;
        if (m_s2 != m_deb) begin
            m_run = m_run + 1;
            if (m_run == DEB) begin
                m_deb   = m_s2;
                m_run   = 0;
                m_press = m_deb;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = int'(BTN);
        m_strobe = 0;
        case (m_mode)
            0: begin
                if (m_press != 0) begin
                    m_mode = 1;
                    m_ev   = m_val[m_fsel];
                    m_gap  = AW;
                end else if (rotary_event) begin
                    m_fsel = (m_fsel + (rotary_right ? 1 : 2)) % 3;
                end
            end
            1: begin
                if (m_press != 0) begin
                    m_val[m_fsel] = m_ev;
                    m_strobe = 1;
                    m_mode   = 2;
                end else if (rotary_event) begin
                    m_step = (m_gap < AW) ? FS : 1;
                    if (rotary_right) m_ev = (m_ev + m_step > MAXV) ? MAXV : m_ev + m_step;
                    else              m_ev = (m_ev < m_step) ? 0 : m_ev - m_step;
                    m_gap = 0;
                end else if (m_gap < AW) begin
                    m_gap = m_gap + 1;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) model_reset();
        else        model_step();
    end

    function automatic logic [35:0] dut_outs();
        return {field_sel, edit_mode, edit_value, value0, value1, value2, update_strobe};
    endfunction

    // Every-cycle comparison of all outputs against the model
    always @(negedge CLK) begin
        logic [35:0] exp_v;
        if (RST_N) begin
            exp_v = {2'(m_fsel), (m_mode == 1), 8'(m_ev), 8'(m_val[0]), 8'(m_val[1]),
                     8'(m_val[2]), (m_strobe != 0)};
            n_cmp = n_cmp + 1;
            if (dut_outs() !== exp_v) begin
                n_bad = n_bad + 1;
                $display("FAIL model_compare t=%0t actual=%h required=%h", $time, dut_outs(), exp_v);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic chk(string name, longint act, longint exp_v);
        n_cmp = n_cmp + 1;
        if (act != exp_v) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp_v);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge CLK);
    endtask

    // Detent sampled exactly 'gap' edges after the previous one
    task automatic rot(bit right, int gap);
        repeat (gap - 1) @(negedge CLK);
        rotary_event = 1'b1;
        rotary_right = right;
        @(negedge CLK);
        rotary_event = 1'b0;
    endtask

    // Raise the button and stop right after the press edge (6th edge)
    task automatic btn_edge();
        BTN = 1'b1;
        idle(6);
    endtask

    task automatic btn_finish();
        idle(4);
        BTN = 1'b0;
        idle(10);
    endtask

    initial begin
        idle(3);
        chk("reset_outputs", dut_outs(), 0);
        RST_N = 1'b1;
        idle(2);

        // Browse navigation with wrap in both directions
        rot(1, 20); chk("browse_r1", field_sel, 1);
        rot(1, 20); chk("browse_r2", field_sel, 2);
        rot(1, 20); chk("browse_r3", field_sel, 0);
        rot(1, 20); chk("browse_r4", field_sel, 1);
        rot(0, 20); chk("browse_l1", field_sel, 0);
        rot(0, 20); chk("browse_l2", field_sel, 2);
        chk("browse_edit_mode", edit_mode, 0);
        rot(0, 20); chk("browse_l3", field_sel, 1);

        // Press latency, slow edits, commit to field 1
        BTN = 1'b1;
        idle(5); chk("press_not_yet", edit_mode, 0);
        idle(1); chk("press_edit", edit_mode, 1);
        chk("edit_load", edit_value, 0);
        idle(4); BTN = 1'b0; idle(10);
        rot(1, 20); chk("slow1", edit_value, 1);
        rot(1, 20); chk("slow2", edit_value, 2);
        rot(1, 20); chk("slow3", edit_value, 3);
        btn_edge();
        chk("commit_strobe", update_strobe, 1);
        chk("commit_value1", value1, 3);
        chk("commit_value0", value0, 0);
        chk("commit_value2", value2, 0);
        chk("commit_edit_mode", edit_mode, 0);
        idle(1); chk("strobe_one_cycle", update_strobe, 0);
        btn_finish();

        // Acceleration on field 0
        rot(0, 20); chk("to_field0", field_sel, 0);
        btn_edge(); chk("edit_f0", edit_mode, 1); btn_finish();
        rot(1, 20); chk("accel_a", edit_value, 1);
        rot(1, 5);  chk("accel_b", edit_value, 5);
        rot(1, 5);  chk("accel_c", edit_value, 9);
        rot(1, 30); chk("accel_d", edit_value, 10);

        // Saturation at both ends
        rot(1, 20); rot(1, 20); rot(1, 20);
        chk("slow_to_13", edit_value, 13);
        for (int i = 0; i < 60; i++) rot(1, 3);
        chk("fast_253", edit_value, 253);
        rot(1, 3); chk("sat_hi1", edit_value, 255);
        rot(1, 3); chk("sat_hi2", edit_value, 255);
        for (int i = 0; i < 63; i++) rot(0, 3);
        chk("fast_down_3", edit_value, 3);
        rot(0, 20); chk("slow_down_2", edit_value, 2);
        rot(0, 3);  chk("sat_lo1", edit_value, 0);
        rot(0, 3);  chk("sat_lo2", edit_value, 0);
        btn_edge(); chk("commit2_strobe", update_strobe, 1); btn_finish();

        // Glitching button produces no press
        for (int i = 0; i < 10; i++) begin
            BTN = ~BTN;
            idle(2);
        end
        BTN = 1'b0;
        idle(10);
        chk("glitch_edit_mode", edit_mode, 0);
        chk("glitch_field", field_sel, 0);

        // Press coincident with a detent: press wins
        BTN = 1'b1;
        idle(5);
        rotary_event = 1'b1; rotary_right = 1'b1;
        idle(1);
        rotary_event = 1'b0;
        chk("coinc_edit", edit_mode, 1);
        chk("coinc_field", field_sel, 0);
        chk("coinc_value", edit_value, 0);
        btn_finish();

        // Asynchronous reset mid-edit
        for (int i = 0; i < 7; i++) rot(1, 20);
        chk("pre_reset_7", edit_value, 7);
        #2 RST_N = 1'b0;
        #1 chk("async_reset", dut_outs(), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        idle(2);
        btn_edge();
        chk("post_reset_edit", edit_mode, 1);
        chk("post_reset_value", edit_value, 0);
        btn_finish();

        // Randomized phase, checked by the model every cycle
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                int hold;
                hold = $urandom_range(1, 12);
                BTN = 1'b1;
                for (int c = 0; c < hold; c++) begin
                    rotary_event = ($urandom_range(0, 3) == 0);
                    rotary_right = 1'($urandom);
                    @(negedge CLK);
                end
                BTN = 1'b0;
                rotary_event = 1'b0;
                idle(8);
            end else begin
                int n;
                n = $urandom_range(5, 40);
                for (int c = 0; c < n; c++) begin
                    rotary_event = ($urandom_range(0, 2) == 0);
                    rotary_right = 1'($urandom);
                    @(negedge CLK);
                end
                rotary_event = 1'b0;
            end
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
